// File: rtl/freq_meter_pkg.sv
// Shared types for the frequency meter: FSM encoding and gate counter sizing.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StGate = 2'd2,
        StDone = 2'd3
    } state_e;

    function automatic int unsigned gate_cnt_width(input int unsigned gate_cycles);
        return (gate_cycles > 1) ? $clog2(gate_cycles) : 1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous input and emits a one-cycle pulse on each rising edge.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed gate window of system clocks.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             sig_in,
    output logic             busy,
    output logic [CNT_W-1:0] freq_count,
    output logic             count_valid,
    output logic             overflow
);

    localparam int unsigned      GW        = gate_cnt_width(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e           state_q, state_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] freq_count_q, freq_count_d;
    logic             ovf_flag_q, ovf_flag_d;
    logic             overflow_q, overflow_d;
    logic             count_valid_q, count_valid_d;
    logic             rise;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_det (
        .clock  (clock),
        .reset_n(reset_n),
        .sig_in (sig_in),
        .rise   (rise)
    );

    always_comb begin
        state_d       = state_q;
        gate_cnt_d    = gate_cnt_q;
        edge_cnt_d    = edge_cnt_q;
        ovf_flag_d    = ovf_flag_q;
        freq_count_d  = freq_count_q;
        overflow_d    = overflow_q;
        count_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start || continuous) state_d = StArm;
            end
            StArm: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                ovf_flag_d = 1'b0;
                state_d    = StGate;
            end
            StGate: begin
                gate_cnt_d = gate_cnt_q + 1'b1;
                if (rise) begin
                    if (edge_cnt_q == CNT_MAX) ovf_flag_d = 1'b1;
                    else                       edge_cnt_d = edge_cnt_q + 1'b1;
                end
                // Result registers load on entry to DONE so they line up with the strobe.
                if (gate_cnt_q == GATE_LAST) begin
                    state_d       = StDone;
                    freq_count_d  = edge_cnt_d;
                    overflow_d    = ovf_flag_d;
                    count_valid_d = 1'b1;
                end
            end
            StDone: begin
                state_d = continuous ? StArm : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            gate_cnt_q    <= '0;
            edge_cnt_q    <= '0;
            ovf_flag_q    <= 1'b0;
            freq_count_q  <= '0;
            overflow_q    <= 1'b0;
            count_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gate_cnt_q    <= gate_cnt_d;
            edge_cnt_q    <= edge_cnt_d;
            ovf_flag_q    <= ovf_flag_d;
            freq_count_q  <= freq_count_d;
            overflow_q    <= overflow_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign freq_count  = freq_count_q;
    assign overflow    = overflow_q;
    assign count_valid = count_valid_q;

endmodule
